// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared state encoding and width helper for the scanning mux
package mux_scan_pkg;

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_e;

    // Select and counter fields are never narrower than one bit, even for a count of 1 or 2.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_scan_dwell.sv
// rtl/mux_scan_dwell.sv - dwell counter with clear, hold and terminal-count flag
module mux_scan_dwell
    import mux_scan_pkg::*;
#(
    parameter int  DWELL = 4,
    localparam int CNTW  = clog2_min1(DWELL)
) (
    input  logic clock_i,
    input  logic resetn_i,
    input  logic clr_i,
    input  logic hold_i,
    output logic tc_o
);

    logic [CNTW-1:0] cnt_q, cnt_d;

    assign tc_o = (int'(cnt_q) == DWELL - 1);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (!hold_i) begin
            cnt_d = tc_o ? '0 : cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_nto1.sv
// rtl/mux_scan_nto1.sv - N-to-1 registered mux with manual select and dwell-timed channel scan
// Optional: define MUX_SCAN_SYNC_EN to pass sel/auto/hold through two-flop synchronizers.
module mux_scan_nto1
    import mux_scan_pkg::*;
#(
    parameter int  WIDTH    = 1,
    parameter int  CHANNELS = 4,
    parameter int  DWELL    = 4,
    localparam int SELW     = clog2_min1(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SELW-1:0]           sel,
    input  logic                      auto,
    input  logic                      hold,
    output logic [WIDTH-1:0]          m,
    output logic [SELW-1:0]           chan,
    output logic                      step
);

    logic [SELW-1:0] sel_s;
    logic            auto_s;
    logic            hold_s;

`ifdef MUX_SCAN_SYNC_EN
    logic [SELW-1:0] sel_m_q, sel_s_q;
    logic            auto_m_q, auto_s_q;
    logic            hold_m_q, hold_s_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sel_m_q  <= '0;
            sel_s_q  <= '0;
            auto_m_q <= 1'b0;
            auto_s_q <= 1'b0;
            hold_m_q <= 1'b0;
            hold_s_q <= 1'b0;
        end else begin
            sel_m_q  <= sel;
            sel_s_q  <= sel_m_q;
            auto_m_q <= auto;
            auto_s_q <= auto_m_q;
            hold_m_q <= hold;
            hold_s_q <= hold_m_q;
        end
    end

    assign sel_s  = sel_s_q;
    assign auto_s = auto_s_q;
    assign hold_s = hold_s_q;
`else
    assign sel_s  = sel;
    assign auto_s = auto;
    assign hold_s = hold;
`endif

    state_e           state_q, state_d;
    logic [SELW-1:0]  chan_q, chan_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             step_q;
    logic             sel_ok;
    logic             cnt_clr;
    logic             cnt_tc;

    assign sel_ok  = (int'(sel_s) < CHANNELS);
    // The counter only runs while already in SCAN with auto still asserted.
    assign cnt_clr = !((state_q == SCAN) && auto_s);

    mux_scan_dwell #(
        .DWELL(DWELL)
    ) u_dwell (
        .clock_i (clock),
        .resetn_i(resetn),
        .clr_i   (cnt_clr),
        .hold_i  (hold_s),
        .tc_o    (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        case (state_q)
            MANUAL: begin
                if (auto_s) begin
                    state_d = SCAN;
                end else if (sel_ok) begin
                    chan_d = sel_s;
                end
            end
            SCAN: begin
                if (!auto_s) begin
                    state_d = MANUAL;
                    if (sel_ok) begin
                        chan_d = sel_s;
                    end
                end else if (!hold_s && cnt_tc) begin
                    chan_d = (int'(chan_q) == CHANNELS - 1) ? '0 : chan_q + SELW'(1);
                end
            end
            default: state_d = MANUAL;
        endcase
    end

    always_comb begin
        m_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (int'(chan_q) == k) begin
                m_d = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= MANUAL;
            chan_q  <= '0;
            m_q     <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            m_q     <= m_d;
            step_q  <= (chan_d != chan_q);
        end
    end

    assign m    = m_q;
    assign chan = chan_q;
    assign step = step_q;

endmodule

// File: tb/tb_mux_scan_nto1.sv
// tb/tb_mux_scan_nto1.sv - directed self-checking bench for mux_scan_nto1
module tb_mux_scan_nto1;

    logic        clock;
    logic        resetn;
    logic [15:0] data_in;
    logic [1:0]  sel;
    logic        auto;
    logic        hold;
    logic [3:0]  m;
    logic [1:0]  chan;
    logic        step;

    logic [11:0] data_in3;
    logic [1:0]  sel3;
    logic        auto3;
    logic        hold3;
    logic [3:0]  m3;
    logic [1:0]  chan3;
    logic        step3;

    int checks;
    int errors;

    mux_scan_nto1 #(.WIDTH(4), .CHANNELS(4), .DWELL(3)) u_dut (
        .clock  (clock),
        .resetn (resetn),
        .data_in(data_in),
        .sel    (sel),
        .auto   (auto),
        .hold   (hold),
        .m      (m),
        .chan   (chan),
        .step   (step)
    );

    mux_scan_nto1 #(.WIDTH(4), .CHANNELS(3), .DWELL(3)) u_dut3 (
        .clock  (clock),
        .resetn (resetn),
        .data_in(data_in3),
        .sel    (sel3),
        .auto   (auto3),
        .hold   (hold3),
        .m      (m3),
        .chan   (chan3),
        .step   (step3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] dat(input int c);
        case (c)
            0:       return 4'hA;
            1:       return 4'hB;
            2:       return 4'hC;
            default: return 4'hD;
        endcase
    endfunction

    initial begin
        int cur;
        int exp_ch;
        checks   = 0;
        errors   = 0;
        resetn   = 1'b0;
        data_in  = {4'hD, 4'hC, 4'hB, 4'hA};
        sel      = 2'd2;
        auto     = 1'b0;
        hold     = 1'b0;
        data_in3 = {4'hC, 4'hB, 4'hA};
        sel3     = 2'd1;
        auto3    = 1'b0;
        hold3    = 1'b0;

        #3;
        check("rst_m", m, 0);
        check("rst_chan", chan, 0);
        check("rst_step", step, 0);
        tick();
        check("rst_hold_chan", chan, 0);
        check("rst_hold_m", m, 0);

        // Manual select straight out of reset
        @(negedge clock);
        resetn = 1'b1;
        tick();
        check("man_chan_e1", chan, 2);
        check("man_step_e1", step, 1);
        check("man_m_e1", m, 4'hA);
        tick();
        check("man_chan_e2", chan, 2);
        check("man_step_e2", step, 0);
        check("man_m_e2", m, 4'hC);

        // Out-of-range select on the three-channel instance
        check("inv_pre_chan", chan3, 1);
        sel3 = 2'd3;
        tick();
        check("inv_chan_e1", chan3, 1);
        check("inv_step_e1", step3, 0);
        tick();
        check("inv_chan_e2", chan3, 1);
        check("inv_m", m3, 4'hB);
        sel3 = 2'd2;
        tick();
        check("inv_recover_chan", chan3, 2);
        check("inv_recover_step", step3, 1);

        // Scan from channel 0
        sel = 2'd0;
        tick();
        check("pre_scan_chan", chan, 0);
        check("pre_scan_step", step, 1);
        tick();
        auto = 1'b1;
        tick();
        check("scan_entry_chan", chan, 0);
        check("scan_entry_step", step, 0);
        cur = 0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 3; j++) begin
                tick();
                exp_ch = (j == 2) ? (cur + 1) % 4 : cur;
                check($sformatf("scan_chan_%0d_%0d", k, j), chan, exp_ch);
                check($sformatf("scan_step_%0d_%0d", k, j), step, (j == 2) ? 1 : 0);
                check($sformatf("scan_m_%0d_%0d", k, j), m, dat(cur));
            end
            cur = (cur + 1) % 4;
        end

        // Hold for five cycles after one unheld dwell cycle
        tick();
        check("hold_pre_chan", chan, 0);
        hold = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick();
            check($sformatf("hold_chan_%0d", j), chan, 0);
            check($sformatf("hold_step_%0d", j), step, 0);
        end
        hold = 1'b0;
        tick();
        check("hold_resume1_chan", chan, 0);
        tick();
        check("hold_resume2_chan", chan, 1);
        check("hold_resume2_step", step, 1);

        // Drop auto on the terminal-count cycle
        tick();
        tick();
        check("exit_pre_chan", chan, 1);
        auto = 1'b0;
        sel  = 2'd1;
        tick();
        check("exit_chan", chan, 1);
        check("exit_step", step, 0);
        sel = 2'd3;
        tick();
        check("exit_manual_chan", chan, 3);
        check("exit_manual_step", step, 1);

        // Asynchronous reset in the middle of a scan dwell
        auto = 1'b1;
        tick();
        tick();
        check("mid_pre_chan", chan, 3);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_m", m, 0);
        check("mid_rst_chan", chan, 0);
        check("mid_rst_step", step, 0);
        @(negedge clock);
        resetn = 1'b1;
        sel    = 2'd2;
        tick();
        check("post_rst_e1_chan", chan, 0);
        check("post_rst_e1_m", m, 4'hA);
        tick();
        tick();
        check("post_rst_e3_chan", chan, 0);
        tick();
        check("post_rst_e4_chan", chan, 1);
        check("post_rst_e4_step", step, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
